imem_loader: RTL and testbench

Boot-time program loader upstream of `MIPS_core`'s InstructionMemory. It accepts a byte stream over a valid/ready handshake: a 16-bit big-endian word count, then that many 32-bit big-endian instruction words. It packs the bytes into words, writes them sequentially into instruction memory from address 0, and holds the core in reset until the image is complete. This replaces testbench back-door loading with a synthesizable path.

---
 rtl/mips_loader_pkg.sv | 15 +
 rtl/imem_loader_byte_packer.sv | 36 +++
 rtl/imem_loader.sv | 128 ++++++++++++
 tb/tb_imem_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_loader_pkg;

  localparam int unsigned LOADER_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    LOAD,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid pulses
// combinationally with the 4th byte so the caller can register the write.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shreg;
  logic [1:0]  byte_cnt;

  // Shift register and byte counter; partial words survive idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (en) begin
      shreg    <= {shreg[15:0], data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // The completed word includes the byte arriving this cycle.
  always_comb begin
    word_valid = en && (byte_cnt == 2'd3);
    word       = {shreg, data};
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives a big-endian word count followed by that many
// big-endian instruction words, writes them to instruction memory from
// address 0, and holds the core in reset until the image is complete.
module imem_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [15:0]       words_loaded,
  output logic              done,
  output logic              error,
  output logic              core_rst_n
);

  loader_state_t state, next_state;

  logic                    fire;
  logic                    restart;
  logic                    pack_clear;
  logic                    pack_en;
  logic                    set_done;
  logic                    set_error;
  logic                    last_word;
  logic                    word_valid;
  logic [31:0]             word;
  logic [7:0]              count_hi;
  logic [LOADER_CNT_W-1:0] hdr_count;
  logic [LOADER_CNT_W-1:0] n;
  logic [LOADER_CNT_W-1:0] word_cnt;

  assign fire      = in_valid && in_ready;
  assign hdr_count = {count_hi, in_data};
  assign last_word = word_valid && ((word_cnt + 16'd1) == n);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .en         (pack_en),
    .data       (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = HDR0;
      HDR0: if (fire) next_state = HDR1;
      HDR1: begin
        if (fire) begin
          if (hdr_count == '0)                            next_state = DONE;
          else if (hdr_count > LOADER_CNT_W'(DEPTH))      next_state = ERROR;
          else                                            next_state = LOAD;
        end
      end
      LOAD:  if (last_word) next_state = DONE;
      DONE:  if (start) next_state = HDR0;
      ERROR: if (start) next_state = HDR0;
      default: next_state = IDLE;
    endcase
  end

  // Per-state control outputs.
  always_comb begin
    in_ready   = (state == HDR0) || (state == HDR1) || (state == LOAD);
    restart    = ((state == DONE) || (state == ERROR)) && start;
    pack_clear = restart || (state == IDLE);
    pack_en    = fire && (state == LOAD);
    // done lags the DONE state by one cycle after a load so it follows the
    // final write strobe; an empty image sets it straight from HDR1.
    set_done   = (state == DONE) || ((state == HDR1) && fire && (hdr_count == '0));
    set_error  = (state == HDR1) && fire && (hdr_count > LOADER_CNT_W'(DEPTH));
  end

  // Header capture, word counter and registered write/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_hi   <= '0;
      n          <= '0;
      word_cnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      if ((state == HDR0) && fire) count_hi <= in_data;
      if ((state == HDR1) && fire) n <= hdr_count;
      if (word_valid) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= word;
        word_cnt   <= word_cnt + 16'd1;
      end
      if (restart) begin
        word_cnt <= '0;
        done     <= 1'b0;
        error    <= 1'b0;
      end else begin
        if (set_done)  done  <= 1'b1;
        if (set_error) error <= 1'b1;
      end
    end
  end

  assign words_loaded = word_cnt;
  assign core_rst_n   = done;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader.
module tb_imem_loader;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              start = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [15:0]       words_loaded;
  logic              done;
  logic              error;
  logic              core_rst_n;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .start        (start),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .words_loaded (words_loaded),
    .done         (done),
    .error        (error),
    .core_rst_n   (core_rst_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cnt;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: interpret the byte stream directly and queue the writes it implies.
  task automatic push_expected(input logic [7:0] img[$]);
    int unsigned nw;
    if (img.size() < 2) return;
    nw = img[0] * 256 + img[1];
    if (nw > DEPTH) return;
    for (int unsigned w = 0; w < nw; w++) begin
      wr_t e;
      if (2 + 4 * w + 3 >= img.size()) break;
      e.addr = w % DEPTH;
      e.data = {img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]};
      e.cnt  = w + 1;
      sb.push_back(e);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", imem_addr, imem_wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("write_addr", 32'(imem_addr), mon_e.addr);
        chk("write_data", imem_wdata, mon_e.data);
        chk("write_words_loaded", 32'(words_loaded), mon_e.cnt);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 200) begin
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_end(input logic [7:0] img[$]);
    int unsigned nw = img[0] * 256 + img[1];
    if (nw == 0) begin
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_core_rst_n", 32'(core_rst_n), 32'd1);
      chk("empty_words", 32'(words_loaded), 32'd0);
    end else if (nw > DEPTH) begin
      chk("err_flag", 32'(error), 32'd1);
      chk("err_in_ready", 32'(in_ready), 32'd0);
      chk("err_core_rst_n", 32'(core_rst_n), 32'd0);
      chk("err_done", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("err_hold_core_rst_n", 32'(core_rst_n), 32'd0);
      chk("err_words", 32'(words_loaded), 32'd0);
    end else begin
      chk("done_not_early", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      chk("done_after_2", 32'(done), 32'd1);
      chk("core_rst_n_after_2", 32'(core_rst_n), 32'd1);
      chk("words_loaded_final", 32'(words_loaded), 32'(nw));
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_image(input logic [7:0] img[$], input int max_gap);
    push_expected(img);
    foreach (img[i]) send_byte(img[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    check_end(img);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_error", 32'(error), 32'd0);
    chk("restart_words", 32'(words_loaded), 32'd0);
    chk("restart_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] img1[$];
    logic [7:0] img[$];

    img1 = '{8'h00, 8'h03, 8'h20, 8'h01, 8'h00, 8'h01,
             8'h20, 8'h02, 8'h00, 8'h02, 8'h08, 8'h10, 8'h00, 8'h25};

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;

    // Back-to-back three-word image.
    run_image(img1, 0);

    // Empty image.
    pulse_start();
    img = '{8'h00, 8'h00};
    run_image(img, 0);

    // Count of DEPTH + 1 is rejected.
    pulse_start();
    img = '{8'h02, 8'h01};
    run_image(img, 0);

    // Same image with random idle gaps, restarted from ERROR.
    pulse_start();
    run_image(img1, 5);

    // start outside DONE/ERROR is ignored mid-load.
    pulse_start();
    push_expected(img1);
    for (int i = 0; i < 4; i++) send_byte(img1[i], 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 4; i < img1.size(); i++) send_byte(img1[i], 0);
    check_end(img1);

    // Reset asserted after six bytes aborts the load.
    pulse_start();
    img = '{};
    for (int i = 0; i < 6; i++) img.push_back(img1[i]);
    push_expected(img);
    foreach (img[i]) send_byte(img[i], 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_reset_values("abort");
    chk("abort_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_image(img1, 0);

    // Reload a single zero word.
    pulse_start();
    img = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    run_image(img, 0);

    // Random small images with random gaps.
    for (int t = 0; t < 6; t++) begin
      int unsigned nw = $urandom_range(8, 1);
      pulse_start();
      img = '{8'h00, 8'(nw)};
      for (int unsigned k = 0; k < 4 * nw; k++) img.push_back(8'($urandom));
      run_image(img, (t % 2 == 0) ? 3 : 0);
    end

    // Largest legal image, filling every address.
    pulse_start();
    img = '{8'h02, 8'h00};
    for (int k = 0; k < 4 * DEPTH; k++) img.push_back(8'($urandom));
    run_image(img, 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
